pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It owns the enable and flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four hazards: data-memory wait states, taken-branch/jump redirects, load-use dependencies, and multi-cycle MULT/DIV (HI/LO) occupancy. It sits beside the control unit, consuming decoded stage information and producing per-cycle stall/flush decisions, plus a stall statistic and a memory-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: memory wait, redirect, load-use and MULT/DIV hazards.
// Strobes are combinational (zero latency); stall count, MDU busy and timeout flag are registered.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_mdu,
    input  logic             id_reads_hilo,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    localparam int MDU_W  = (MDU_CYCLES  > 0) ? $clog2(MDU_CYCLES + 1)  : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [MDU_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic               mdu_busy_q, mdu_busy_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_err_q, mem_err_d;

    logic mem_wait, load_use, mdu_haz;

    always_comb begin
        mem_wait = dmem_req & ~dmem_ready;
        load_use = ex_is_load & (ex_wreg != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_wreg)) | (id_uses_rt & (id_rt == ex_wreg)));
        mdu_haz  = mdu_busy_q & (id_is_mdu | id_reads_hilo);

        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_start  = 1'b0;

        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, so its hazards are irrelevant
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use | mdu_haz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            mdu_start = id_is_mdu;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_RUN) begin
            if (mem_wait) begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
        end else if (mem_wait) begin
            if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT))
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            state_d = ST_RUN;
        end
        mem_err_d = mem_err_q | ((state_d == ST_WAIT) && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)));

        // A new start reloads even if the previous run is on its last cycle
        if (mdu_start)
            mdu_cnt_d = MDU_W'(MDU_CYCLES);
        else if (mdu_cnt_q != '0)
            mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
        else
            mdu_cnt_d = mdu_cnt_q;
        mdu_busy_d = (mdu_cnt_d != '0);

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mdu_cnt_q   <= '0;
            mdu_busy_q  <= 1'b0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mdu_cnt_q   <= mdu_cnt_d;
            mdu_busy_q  <= mdu_busy_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mdu_busy  = mdu_busy_q;
    assign stall_cnt = stall_cnt_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic against a cycle model.
module tb_pipe_hazard_ctrl;

    localparam int MDU_CYC = 32;
    localparam int TMO     = 4;
    localparam int CW      = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs, id_rt, ex_wreg;
    logic          id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo;
    logic          ex_is_load, ex_redirect, dmem_req, dmem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, mdu_start, mdu_busy, mem_err;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: remaining MDU busy cycles, stall total, current wait run length, timeout flag
    int m_mdu = 0;
    int m_stall = 0;
    int m_run = 0;
    int m_err = 0;

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU_CYC), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
        .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mdu_start(mdu_start),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_wreg = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_mdu = 1'b0; id_reads_hilo = 1'b0;
        ex_is_load = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Cycle model: expected strobes from the priority rules, registered outputs from model state
    always @(negedge clk) begin
        logic [4:0] e_en;
        logic [1:0] e_fl;
        logic       e_start, lu, haz, waitc;
        waitc = dmem_req && !dmem_ready;
        lu = ex_is_load && (ex_wreg != 5'd0) &&
             ((id_uses_rs && id_rs == ex_wreg) || (id_uses_rt && id_rt == ex_wreg));
        haz = lu || ((m_mdu > 0) && (id_is_mdu || id_reads_hilo));
        e_start = 1'b0;
        if (!rst_n)           begin e_en = 5'b00000; e_fl = 2'b11; end
        else if (waitc)       begin e_en = 5'b00000; e_fl = 2'b00; end
        else if (ex_redirect) begin e_en = 5'b11111; e_fl = 2'b11; end
        else if (haz)         begin e_en = 5'b00111; e_fl = 2'b01; end
        else begin e_en = 5'b11111; e_fl = 2'b00; e_start = id_is_mdu; end

        check("strobes", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mdu_start}),
              32'({e_en, e_fl, e_start}));
        check("mdu_busy", 32'(mdu_busy), 32'(m_mdu > 0));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("mem_err", 32'(mem_err), 32'(m_err));

        if (!rst_n) begin
            m_mdu = 0; m_stall = 0; m_run = 0; m_err = 0;
        end else begin
            if (e_start) m_mdu = MDU_CYC;
            else if (m_mdu > 0) m_mdu = m_mdu - 1;
            if (!e_en[4] && m_stall < (1 << CW) - 1) m_stall = m_stall + 1;
            m_run = waitc ? m_run + 1 : 0;
            if (m_run >= TMO + 1) m_err = 1;
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        step(); step();
        check("rst_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(0));
        check("rst_flush", 32'({ifid_flush, idex_flush, mdu_start}), 32'(3'b110));
        step(); rst_n = 1'b1; #1;
        check("post_rst_regs", 32'({stall_cnt, mdu_busy, mem_err}), 32'(0));
        check("run_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(5'b11111));

        // load-use: one bubble, then release
        step(); idle(); ex_is_load = 1'b1; ex_wreg = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5; #1;
        check("lu_stall", 32'({pc_en, ifid_en, idex_flush, exmem_en, memwb_en}), 32'(5'b00111));
        step(); idle(); #1;
        check("lu_release", 32'({pc_en, ifid_en, idex_en, idex_flush}), 32'(4'b1110));
        check("lu_cnt", 32'(stall_cnt), 32'(1));
        step(); idle(); ex_is_load = 1'b1; ex_wreg = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0; #1;
        check("lu_r0", 32'({pc_en, idex_flush}), 32'(2'b10));

        // redirect beats load-use
        step(); idle(); ex_is_load = 1'b1; ex_wreg = 5'd7; id_uses_rt = 1'b1; id_rt = 5'd7; ex_redirect = 1'b1; #1;
        check("redir_lu", 32'({pc_en, ifid_en, ifid_flush, idex_flush}), 32'(4'b1111));
        step(); idle(); #1;
        check("redir_cnt", 32'(stall_cnt), 32'(1));

        // memory wait with pending redirect
        for (int i = 0; i < 3; i++) begin
            step(); idle(); dmem_req = 1'b1; ex_redirect = 1'b1; #1;
            check("mw_frozen", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}), 32'(0));
        end
        step(); idle(); dmem_req = 1'b1; dmem_ready = 1'b1; ex_redirect = 1'b1; #1;
        check("mw_release", 32'({pc_en, ifid_flush, idex_flush}), 32'(3'b111));
        step(); idle(); #1;
        check("mw_cnt", 32'(stall_cnt), 32'(4));
        check("mw_no_err", 32'(mem_err), 32'(0));

        // timeout after TMO cycles in WAIT
        for (int i = 1; i <= 6; i++) begin
            step(); idle(); dmem_req = 1'b1; #1;
            if (i == 4) check("tmo_early", 32'(mem_err), 32'(0));
            if (i == 6) check("tmo_err", 32'(mem_err), 32'(1));
        end
        step(); idle(); dmem_req = 1'b1; dmem_ready = 1'b1; #1;
        check("tmo_release", 32'({pc_en, mem_err}), 32'(2'b11));
        step(); idle(); #1;
        check("tmo_sticky", 32'(mem_err), 32'(1));
        check("tmo_cnt", 32'(stall_cnt), 32'(10));

        // DIV then dependent MFLO
        step(); idle(); id_is_mdu = 1'b1; #1;
        check("div_start", 32'({mdu_start, pc_en, mdu_busy}), 32'(3'b110));
        for (int i = 1; i <= 33; i++) begin
            step(); idle(); id_reads_hilo = 1'b1; #1;
            if (i <= 32) check("mflo_stall", 32'({pc_en, mdu_busy, mdu_start, idex_flush}), 32'(4'b0101));
            else         check("mflo_go", 32'({pc_en, mdu_busy, idex_flush}), 32'(3'b100));
        end
        step(); idle(); #1;
        check("mdu_cnt", 32'(stall_cnt), 32'(42));

        // back-to-back DIV, then reset mid-divide
        step(); idle(); id_is_mdu = 1'b1; #1;
        check("div2_start", 32'(mdu_start), 32'(1));
        for (int i = 0; i < 22; i++) begin
            step(); idle(); id_is_mdu = 1'b1; #1;
            if (i == 0) check("div2_stall", 32'({pc_en, mdu_start, idex_flush}), 32'(3'b001));
        end
        step(); idle(); id_is_mdu = 1'b1; rst_n = 1'b0; #1;
        check("rst_mid_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, mdu_start}), 32'(0));
        check("rst_mid_flush", 32'({ifid_flush, idex_flush}), 32'(2'b11));
        step(); idle(); rst_n = 1'b1; #1;
        check("rst_mid_regs", 32'({mdu_busy, stall_cnt, mem_err}), 32'(0));

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            rst_n         = ($urandom_range(0, 599) != 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_wreg       = 5'($urandom_range(0, 3));
            id_uses_rs    = 1'($urandom_range(0, 1));
            id_uses_rt    = 1'($urandom_range(0, 1));
            id_is_mdu     = ($urandom_range(0, 9) == 0);
            id_reads_hilo = ($urandom_range(0, 7) == 0);
            ex_is_load    = ($urandom_range(0, 2) == 0);
            ex_redirect   = ($urandom_range(0, 9) == 0);
            dmem_req      = ($urandom_range(0, 2) == 0);
            dmem_ready    = ($urandom_range(0, 9) < 4);
        end
        step(); idle(); rst_n = 1'b1;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
